// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, register addresses and parity helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    // Callers zero-extend shorter characters so unused high bits do not disturb the XOR.
    function automatic logic parity_calc(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy counter; push while full is accepted alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - bus-attached UART transmitter with transmit FIFO, optional parity and 1/2 stop bits
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          brg_full,
    input  logic                          iocs,
    input  logic                          iorw,
    input  logic [1:0]                    ioaddr,
    input  logic [7:0]                    databus,
    output logic                          tbr,
    output logic                          tx_empty,
    output logic                          tx_ovr,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          txd
);

    logic                 push;
    logic                 pop;
    logic                 ovr_set;
    logic                 ovr_clr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic [DATA_BITS-1:0] char_q;
    logic [DATA_BITS-1:0] char_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic                 stop_cnt;
    logic                 stop_cnt_next;
    logic                 load;
    logic                 txd_next;

    assign push    = iocs & ~iorw & (ioaddr == ADDR_DATA);
    assign ovr_clr = iocs & ~iorw & (ioaddr == ADDR_STATUS);
    assign ovr_set = push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (databus[DATA_BITS-1:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (tx_level)
    );

    assign tbr      = ~fifo_full;
    assign tx_empty = fifo_empty & (state == IDLE);

    always_comb begin
        state_next    = state;
        shreg_next    = shreg;
        char_next     = char_q;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        load          = 1'b0;
        pop           = 1'b0;
        if (brg_full) begin
            case (state)
                IDLE:   load = 1'b1;
                START: begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
                DATA: begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        state_next    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_next = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                end
                STOP: begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        load = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        // End of a stop interval (or an idle tick) chains straight into the next queued character.
        if (load) begin
            state_next = IDLE;
            if (!fifo_empty) begin
                pop        = 1'b1;
                shreg_next = fifo_head;
                char_next  = fifo_head;
                state_next = START;
            end
        end
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shreg_next[0];
            PARITY:  txd_next = parity_calc(8'(char_q), 1'(PARITY_ODD));
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            char_q   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
            tx_ovr   <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            char_q   <= char_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            txd      <= txd_next;
            if (ovr_set) begin
                tx_ovr <= 1'b1;
            end else if (ovr_clr) begin
                tx_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench: 8N1 and 7O2 transmitters checked against a frame-level model
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          start;
    } frame_t;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       brg_full;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus;

    int checks = 0;
    int errors = 0;
    int period = 0;
    int phase  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int chn, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h", name, chn, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int DB   = (g == 0) ? 8 : 7;
        localparam int PEN  = g;
        localparam int PODD = g;
        localparam int SB   = g + 1;
        localparam int FL   = 1 + DB + PEN + SB;

        logic       tbr;
        logic       tx_empty;
        logic       tx_ovr;
        logic       txd;
        logic [2:0] tx_level;

        uart_tx_fifo #(
            .DATA_BITS  (DB),
            .FIFO_DEPTH (DEPTH),
            .PARITY_EN  (PEN),
            .PARITY_ODD (PODD),
            .STOP_BITS  (SB)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .brg_full (brg_full),
            .iocs     (iocs),
            .iorw     (iorw),
            .ioaddr   (ioaddr),
            .databus  (databus),
            .tbr      (tbr),
            .tx_empty (tx_empty),
            .tx_ovr   (tx_ovr),
            .tx_level (tx_level),
            .txd      (txd)
        );

        logic [7:0]  q[$];
        frame_t      exp_q[$];
        int          busy     = 0;
        int          qlen     = 0;
        int          tick_num = 0;
        logic        ovr      = 1'b0;
        logic        in_frame = 1'b0;
        int          pend     = 0;
        int          idx      = 0;
        frame_t      cur;
        logic [15:0] rx       = '0;
        logic [15:0] last_rx  = '0;

        function automatic frame_t make_frame(input logic [7:0] d, input int start);
            frame_t f;
            logic   p;
            f.bits  = '0;
            f.len   = FL;
            f.start = start;
            p       = (PODD != 0);
            for (int i = 0; i < DB; i++) begin
                f.bits[1+i] = d[i];
                p = p ^ d[i];
            end
            if (PEN != 0) f.bits[1+DB] = p;
            for (int i = 0; i < SB; i++) f.bits[1+DB+PEN+i] = 1'b1;
            return f;
        endfunction

        // Reference model: busy counts ticks left in the current frame.
        initial forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                exp_q.delete();
                busy = 0;
                ovr  = 1'b0;
            end else begin
                logic set;
                set = 1'b0;
                if (brg_full) begin
                    tick_num++;
                    if (busy > 1) begin
                        busy--;
                    end else if (q.size() > 0) begin
                        exp_q.push_back(make_frame(q.pop_front(), tick_num + 1));
                        busy = FL;
                    end else begin
                        busy = 0;
                    end
                end
                if (iocs && !iorw && ioaddr == 2'd0) begin
                    if (q.size() < DEPTH) q.push_back(databus);
                    else set = 1'b1;
                end
                if (iocs && !iorw && ioaddr == 2'd1) ovr = 1'b0;
                if (set) ovr = 1'b1;
            end
            qlen = q.size();
        end

        // Monitor: status outputs every cycle, txd sampled at the end of every bit interval.
        initial forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                check("tx_level", g, tx_level, q.size());
                check("tbr", g, tbr, q.size() < DEPTH);
                check("tx_empty", g, tx_empty, q.size() == 0 && busy == 0);
                check("tx_ovr", g, tx_ovr, ovr);
                if (busy == 0) check("idle_txd", g, txd, 1);
                if (brg_full) begin
                    if (!in_frame && txd == 1'b0) begin
                        check("frame_expected", g, exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            cur = exp_q.pop_front();
                            check("start_tick", g, tick_num + 1, cur.start);
                        end else begin
                            cur = make_frame(8'h00, 0);
                        end
                        rx       = '0;
                        idx      = 1;
                        in_frame = 1'b1;
                    end else if (in_frame) begin
                        check("frame_bit", g, txd, cur.bits[idx]);
                        rx[idx] = txd;
                        idx++;
                        if (idx == cur.len) begin
                            in_frame = 1'b0;
                            last_rx  = rx;
                        end
                    end
                end
            end
            pend = exp_q.size() + (in_frame ? 1 : 0);
        end
    end

    task automatic step(input logic tk = 1'b0, input logic cs = 1'b0, input logic rw = 1'b0,
                        input logic [1:0] a = 2'd0, input logic [7:0] d = 8'h00);
        logic auto_tk;
        auto_tk  = (period != 0) && (phase == period - 1);
        brg_full = tk | auto_tk;
        phase    = (period == 0 || auto_tk) ? 0 : phase + 1;
        iocs     = cs;
        iorw     = rw;
        ioaddr   = a;
        databus  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic tk = 1'b0);
        step(tk, 1'b1, 1'b0, a, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ch[0].busy != 0 || ch[0].qlen != 0 || ch[1].busy != 0 || ch[1].qlen != 0) && n < 4000) begin
            step();
            n++;
        end
        repeat (3) step();
        check("drain_timeout", 0, n < 4000, 1);
        check("frames_pending", 0, ch[0].pend, 0);
        check("frames_pending", 1, ch[1].pend, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int r;
        rst      = 1'b1;
        brg_full = 1'b0;
        iocs     = 1'b0;
        iorw     = 1'b0;
        ioaddr   = 2'd0;
        databus  = 8'h00;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_txd", 0, ch[0].txd, 1);
        check("rst_tbr", 0, ch[0].tbr, 1);
        check("rst_tx_empty", 0, ch[0].tx_empty, 1);
        check("rst_level", 0, ch[0].tx_level, 0);

        period = 16;
        wr(2'd0, 8'hA5);
        drain();
        check("a5_frame", 0, ch[0].last_rx, 16'h034A);
        check("a5_tx_empty", 0, ch[0].tx_empty, 1);

        wr(2'd0, 8'h03);
        drain();
        check("p703_frame", 1, ch[1].last_rx, 16'h0706);

        wr(2'd0, 8'h11);
        wr(2'd0, 8'h22);
        wr(2'd0, 8'h33);
        drain();

        period = 0;
        for (int i = 0; i < 5; i++) wr(2'd0, 8'h41 + 8'(i));
        check("full_tbr", 0, ch[0].tbr, 0);
        check("full_ovr", 0, ch[0].tx_ovr, 1);
        check("full_level", 0, ch[0].tx_level, 4);
        wr(2'd1, 8'h00);
        check("ovr_clear", 0, ch[0].tx_ovr, 0);
        period = 16;
        drain();

        period = 0;
        wr(2'd0, 8'h5A, 1'b1);
        check("push_tick_nostart", 0, ch[0].tx_empty, 0);
        step(1'b1);
        for (int i = 0; i < 4; i++) wr(2'd0, 8'h61 + 8'(i));
        n = 0;
        while (ch[0].busy != 1 && n < 50) begin
            step(1'b1);
            n++;
        end
        check("reach_last_stop", 0, n < 50, 1);
        wr(2'd0, 8'h99, 1'b1);
        check("coincide_level", 0, ch[0].tx_level, 4);
        check("coincide_ovr", 0, ch[0].tx_ovr, 0);
        wr(2'd1, 8'h00);
        period = 16;
        drain();

        wr(2'd0, 8'hC3);
        n = 0;
        while (ch[0].busy != 6 && n < 400) begin
            step();
            n++;
        end
        check("reach_bit3", 0, n < 400, 1);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_txd", 0, ch[0].txd, 1);
        check("midrst_level", 0, ch[0].tx_level, 0);
        check("midrst_tx_empty", 0, ch[0].tx_empty, 1);
        step();
        wr(2'd0, 8'h3C);
        drain();
        check("post_rst_frame", 0, ch[0].last_rx, 16'h0278);

        period = $urandom_range(3, 6);
        phase  = 0;
        repeat (400) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      wr(2'd0, 8'($urandom));
            else if (r == 5) wr(2'd1, 8'($urandom));
            else if (r == 6) step(1'b0, 1'b1, 1'b1, 2'($urandom), 8'($urandom));
            else if (r == 7) wr(2'($urandom_range(2, 3)), 8'($urandom));
            else             step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a transmit FIFO, configurable character length, optional parity and 1 or 2 stop bits. Sits on the I/O bus (iocs/iorw/ioaddr/databus) beside the baud-rate generator. It serialises queued characters on txd, one bit per brg_full tick, back-to-back with no idle gap when the FIFO holds data.

Parameters:
DATA_BITS, 8, character length, legal 5..8; databus[DATA_BITS-1:0] is used.
FIFO_DEPTH, 4, FIFO entries, power of 2, >= 2.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits, legal 1 or 2.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
brg_full  in  1  baud tick, one-cycle pulse per bit period.
iocs  in  1  chip select.
iorw  in  1  1 = read, 0 = write.
ioaddr  in  2  register address; 2'd0 = TX data, 2'd1 = status (write clears overrun).
databus  in  8  write data.
tbr  out  1  FIFO not full (transmit buffer ready).
tx_empty  out  1  FIFO empty and FSM in IDLE.
tx_ovr  out  1  sticky overrun flag.
tx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
txd  out  1  serial output, idle high.

Behaviour:
- Reset: txd=1, tbr=1, tx_empty=1, tx_ovr=0, tx_level=0, FIFO flushed, FSM in IDLE. Reset mid-frame aborts the frame; txd is 1 in the cycle after rst is sampled.
- Push: iocs & ~iorw & ioaddr==0. Accepted if not full, or if full and a pop occurs in the same cycle (level unchanged). A push while full with no pop is dropped and sets tx_ovr.
- tx_ovr clears on iocs & ~iorw & ioaddr==1. If a set and a clear coincide, the set wins.
- Reads (iorw=1) and other addresses have no effect.
- All outputs are registered. tx_level and tbr update the cycle after a push or pop.
- FSM states IDLE, START, DATA, PARITY, STOP. All transitions occur only on cycles with brg_full=1; there is no state change between ticks.
- IDLE: txd=1. On a tick with FIFO non-empty: pop the head into the shift register, go to START. txd=0 from the next cycle. A push and a tick in the same cycle with an empty FIFO does not start a frame; the frame starts on the next tick.
- START: txd=0 for one tick interval, then DATA.
- DATA: txd carries data LSB first, one bit per tick. bit_cnt counts 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_EN, else STOP.
- PARITY: txd = XOR of the data bits, inverted when PARITY_ODD; lasts one tick interval.
- STOP: txd=1 for STOP_BITS tick intervals. On the final stop tick, pop and go to START if the FIFO is non-empty, else go to IDLE.
- Frame length is 1 + DATA_BITS + PARITY_EN + STOP_BITS ticks.
- Parity is computed from the latched character, never from the FIFO head.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo the depth. Full and empty are derived from the level counter.
- tx_empty=1 only when the level is 0 and the FSM is in IDLE. It drops the cycle after an accepted push.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Address constants ADDR_DATA=2'd0, ADDR_STATUS=2'd1.
  - Function parity_calc(data, odd).
- Sub-module sync_fifo: parametrised WIDTH/DEPTH, synchronous rst, push/pop/full/empty/level. Same-cycle push and pop when full are legal.
- uart_tx_fifo contains the bus decode, the overrun flag, the FSM and the shift register.

Test Plan:
- Defaults (8N1): write 0xA5, tick every 16 clks -> txd sequence 0,1,0,1,0,0,1,0,1,1, one bit per tick; tx_empty returns to 1 after the stop tick.
- Back-to-back: write 0x11, 0x22, 0x33 -> three frames with no idle bit between the stop and the next start; tx_level steps 3,2,1,0 as each frame starts.
- Depth 4, no ticks: write 5 bytes -> tbr=0 after the 4th write, 5th byte dropped, tx_ovr=1. Write to ioaddr 1 -> tx_ovr=0. Only the first 4 bytes are transmitted.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2: write 0x03 -> start, 1,1,0,0,0,0,0, parity 1, stop, stop (11 ticks).
- FIFO full; push coincides with the tick-driven pop at the end of the stop bit -> push accepted, tx_level stays at 4, tx_ovr stays 0.
- rst asserted during DATA bit 3 -> next cycle txd=1, tx_level=0, state IDLE. A later write transmits a clean frame.
